alu_ctrl_sequencer: RTL

//  Registered successor to the combinational ALU control decode. Sits between decode and the ALU.

---
 rtl/alu_ctrl_sequencer_pkg.sv | 55 +++++
 rtl/alu_ctrl_sequencer_if.sv | 31 +++
 rtl/alu_ctrl_sequencer_decode.sv | 62 ++++++
 rtl/alu_ctrl_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared definitions for the ALU control sequencer: operation class codes,
// function codes within each class, 4-bit ALU control words, sequencer state
// encodings and the set of functions that are executed as iterated shifts.
package alu_ctrl_sequencer_pkg;

  // Operation classes (alu_op)
  localparam int unsigned OP_ADD    = 0;
  localparam int unsigned OP_ADDSUB = 1;
  localparam int unsigned OP_AND    = 2;
  localparam int unsigned OP_LOGIC  = 3;
  localparam int unsigned OP_OR     = 4;
  localparam int unsigned OP_SHIFT  = 5;
  localparam int unsigned OP_LUI    = 6;

  // Function codes within OP_ADDSUB / OP_LOGIC
  localparam int unsigned FUNC_ADD = 0;
  localparam int unsigned FUNC_SUB = 1;
  localparam int unsigned FUNC_XOR = 0;
  localparam int unsigned FUNC_NOR = 1;

  // Function codes within OP_SHIFT (immediate forms and variable forms)
  localparam int unsigned FUNC_SLLI = 0;
  localparam int unsigned FUNC_SRLI = 1;
  localparam int unsigned FUNC_SLL  = 2;
  localparam int unsigned FUNC_SRL  = 3;
  localparam int unsigned FUNC_SRAI = 4;
  localparam int unsigned FUNC_SRA  = 5;

  // ALU control words
  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b0001;
  localparam logic [3:0] CTRL_XOR  = 4'b0010;
  localparam logic [3:0] CTRL_NOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SRA  = 4'b0110;
  localparam logic [3:0] CTRL_LUI  = 4'b0111;
  localparam logic [3:0] CTRL_AND  = 4'b1000;
  localparam logic [3:0] CTRL_OR   = 4'b1001;
  localparam logic [3:0] CTRL_SLLI = 4'b1100;
  localparam logic [3:0] CTRL_SRLI = 4'b1101;
  localparam logic [3:0] CTRL_SRAI = 4'b1110;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SINGLE = 2'd1,
    ST_ITER   = 2'd2
  } state_t;

  // Variable shifts are the ones broken into single-bit passes.
  function automatic logic is_iter_func(input int unsigned fn);
    return (fn == FUNC_SLL) || (fn == FUNC_SRL) || (fn == FUNC_SRA);
  endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_if.sv
// Command/beat bus of the ALU control sequencer.
//   master: drives in_valid/alu_op/func/shamt and out_ready (decode + ALU side)
//   slave : drives in_ready and the registered beat outputs (the sequencer)
interface alu_ctrl_sequencer_if #(
  parameter int OP_W    = 3,
  parameter int FUNC_W  = 5,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    alu_op;
  logic [FUNC_W-1:0]  func;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               out_last;
  logic [SHAMT_W-1:0] out_iter;
  logic               illegal;

  modport master (
    output in_valid, alu_op, func, shamt, out_ready,
    input  in_ready, out_valid, alu_ctrl, out_last, out_iter, illegal
  );

  modport slave (
    input  in_valid, alu_op, func, shamt, out_ready,
    output in_ready, out_valid, alu_ctrl, out_last, out_iter, illegal
  );
endinterface

// File: rtl/alu_ctrl_sequencer_decode.sv
// Combinational ALU control decode.
//   alu_op, func -> alu_ctrl (zero-extended to CTRL_W), illegal, iterate
// func is compared zero-extended; unknown op/func decodes to 0000 with illegal.
// iterate flags a variable shift, independent of whether iteration is enabled.
module alu_ctrl_sequencer_decode
  import alu_ctrl_sequencer_pkg::*;
#(
  parameter int OP_W   = 3,
  parameter int FUNC_W = 5,
  parameter int CTRL_W = 4
) (
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              iterate
);

  int unsigned op_v;
  int unsigned fn_v;
  logic [3:0]  ctrl4;

  always_comb begin
    op_v    = 32'(alu_op);
    fn_v    = 32'(func);
    ctrl4   = 4'b0000;
    illegal = 1'b0;
    iterate = 1'b0;
    case (op_v)
      OP_ADD:    ctrl4 = CTRL_ADD;
      OP_ADDSUB: begin
        if (fn_v == FUNC_ADD)      ctrl4 = CTRL_ADD;
        else if (fn_v == FUNC_SUB) ctrl4 = CTRL_SUB;
        else                       illegal = 1'b1;
      end
      OP_AND:    ctrl4 = CTRL_AND;
      OP_LOGIC: begin
        if (fn_v == FUNC_XOR)      ctrl4 = CTRL_XOR;
        else if (fn_v == FUNC_NOR) ctrl4 = CTRL_NOR;
        else                       illegal = 1'b1;
      end
      OP_OR:     ctrl4 = CTRL_OR;
      OP_SHIFT: begin
        case (fn_v)
          FUNC_SLLI: ctrl4 = CTRL_SLLI;
          FUNC_SRLI: ctrl4 = CTRL_SRLI;
          FUNC_SLL:  ctrl4 = CTRL_SLL;
          FUNC_SRL:  ctrl4 = CTRL_SRL;
          FUNC_SRAI: ctrl4 = CTRL_SRAI;
          FUNC_SRA:  ctrl4 = CTRL_SRA;
          default:   illegal = 1'b1;
        endcase
        iterate = is_iter_func(fn_v);
      end
      OP_LUI:    ctrl4 = CTRL_LUI;
      default:   illegal = 1'b1;
    endcase
  end

  assign alu_ctrl = CTRL_W'(ctrl4);

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// ALU control sequencer: registered successor to the combinational decode.
// Accepts (alu_op, func, shamt) over a valid/ready handshake and presents one
// registered ALU control beat per handshake. With ITER_SHIFT set, variable
// shifts are emitted as shamt single-bit beats (out_iter counts beats left).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; drops any beat in flight
//   bus  - alu_ctrl_sequencer_if.slave: command in, control beat out
module alu_ctrl_sequencer
  import alu_ctrl_sequencer_pkg::*;
#(
  parameter int                OP_W       = 3,
  parameter int                FUNC_W     = 5,
  parameter int                CTRL_W     = 4,
  parameter int                SHAMT_W    = 5,
  parameter bit                ITER_SHIFT = 1'b1,
  parameter logic [CTRL_W-1:0] CTRL_NOP   = CTRL_W'(4'b1111)
) (
  input logic                 clk,
  input logic                 rst,
  alu_ctrl_sequencer_if.slave bus
);

  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_illegal;
  logic               dec_iterate;

  state_t             state_p1;
  logic               vld_p1;
  logic [CTRL_W-1:0]  ctrl_p1;
  logic               last_p1;
  logic [SHAMT_W-1:0] iter_p1;
  logic               illegal_p1;

  logic               out_fire;
  logic               take;
  logic               iter_cmd;

  alu_ctrl_sequencer_decode #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .alu_op   (bus.alu_op),
    .func     (bus.func),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal),
    .iterate  (dec_iterate)
  );

  assign out_fire = vld_p1 & bus.out_ready;
  // A new command may land in the same edge the final beat is consumed,
  // which keeps single-beat commands flowing at one per clock.
  assign bus.in_ready = !rst & ((state_p1 == ST_EMPTY) | (out_fire & last_p1));
  assign take     = bus.in_valid & bus.in_ready;
  assign iter_cmd = ITER_SHIFT & dec_iterate;

  // ---- stage p1: state, beat register and remaining-beat counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1   <= ST_EMPTY;
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      last_p1    <= 1'b0;
      iter_p1    <= '0;
      illegal_p1 <= 1'b0;
    end else if (take) begin
      vld_p1     <= 1'b1;
      illegal_p1 <= dec_illegal;
      if (iter_cmd && (bus.shamt == '0)) begin
        // Zero-length variable shift: ALU passes the operand through.
        ctrl_p1  <= CTRL_NOP;
        last_p1  <= 1'b1;
        iter_p1  <= '0;
        state_p1 <= ST_SINGLE;
      end else if (iter_cmd) begin
        ctrl_p1  <= dec_ctrl;
        iter_p1  <= bus.shamt - SHAMT_W'(1);
        last_p1  <= (bus.shamt == SHAMT_W'(1));
        state_p1 <= (bus.shamt == SHAMT_W'(1)) ? ST_SINGLE : ST_ITER;
      end else begin
        ctrl_p1  <= dec_ctrl;
        last_p1  <= 1'b1;
        iter_p1  <= '0;
        state_p1 <= ST_SINGLE;
      end
    end else if (out_fire) begin
      if (state_p1 == ST_ITER) begin
        // alu_ctrl is held; only the remaining count moves.
        iter_p1 <= iter_p1 - SHAMT_W'(1);
        if (iter_p1 == SHAMT_W'(1)) begin
          last_p1  <= 1'b1;
          state_p1 <= ST_SINGLE;
        end
      end else begin
        vld_p1   <= 1'b0;
        state_p1 <= ST_EMPTY;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.alu_ctrl  = ctrl_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_iter  = iter_p1;
  assign bus.illegal   = illegal_p1;

endmodule
